// File: rtl/mgmt_core_wrapper.sv
// Management-core boot sequencer: reads NBYTES bytes from an SPI flash
// at RD_ADDR and reports every byte plus a progress code on the logic
// analyser bus, then raises a completion flag on the GPIO pad.
module mgmt_core_wrapper #(
    parameter int unsigned  CLK_DIV = 2,
    parameter logic [7:0]   RD_CMD  = 8'h03,
    parameter logic [23:0]  RD_ADDR = 24'h000000,
    parameter int unsigned  NBYTES  = 11
) (
    input  logic         core_clk,
    input  logic         core_rstn,
    output logic [127:0] la_output,
    output logic         gpio_out_pad,
    output logic         spi_clk,
    output logic         spi_cs_n,
    output logic         spi_mosi,
    input  logic         spi_miso,
    output logic         spi_sdoenb,
    output logic         flash_csb,
    output logic         flash_clk,
    output logic         flash_io0,
    input  logic         flash_io1,
    input  logic [31:0]  mprj_dat_i,
    input  logic [31:0]  hk_dat_i,
    input  logic         mprj_ack_i,
    input  logic         hk_ack_i
);

    typedef enum logic [2:0] {START, CMD, ADDR, DATA, REPORT, STOP, DONE} state_e;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [3:0] LAST_BYTE = 4'(NBYTES - 1);

    state_e       state_q, state_d;
    logic         csN_q;
    logic         spiClk_q;
    logic         sdoEnb_q;
    logic [7:0]   divCnt_q;
    logic [4:0]   bitCnt_q;
    logic [2:0]   rxBits_q;
    logic [7:0]   rxSr_q;
    logic [31:0]  txSr_q;
    logic [3:0]   byteCnt_q;
    logic [15:0]  checkbits_q;
    logic [7:0]   spivalue_q;
    logic         done_q;

    logic         inXfer;
    logic         tick;
    logic         riseEv;
    logic         fallEv;
    logic         stopEnd;
    logic         unusedInputs;

    // The divider runs only while chip select is low; STOP keeps it running
    // so the trailing low half-period of spi_clk can be timed.
    assign inXfer  = !csN_q && (state_q inside {CMD, ADDR, DATA, REPORT, STOP});
    assign tick    = inXfer && (divCnt_q == DIV_LAST);
    assign riseEv  = tick && !spiClk_q && (state_q != STOP);
    assign fallEv  = tick && spiClk_q;
    assign stopEnd = tick && !spiClk_q && (state_q == STOP);

    assign unusedInputs = ^{flash_io1, mprj_dat_i, hk_dat_i, mprj_ack_i, hk_ack_i};

    // State register.
    always_ff @(posedge core_clk or posedge core_rstn) begin
        if (core_rstn) state_q <= START;
        else           state_q <= state_d;
    end

    // Next-state logic: phase changes are tied to spi_clk edge events.
    always_comb begin
        state_d = state_q;
        case (state_q)
            START:   state_d = CMD;
            CMD:     if (fallEv && bitCnt_q == 5'd7)  state_d = ADDR;
            ADDR:    if (fallEv && bitCnt_q == 5'd31) state_d = DATA;
            DATA:    if (riseEv && rxBits_q == 3'd7)  state_d = REPORT;
            REPORT:  state_d = (byteCnt_q == LAST_BYTE) ? STOP : DATA;
            STOP:    if (stopEnd) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = START;
        endcase
    end

    // SPI shift engine and report registers; clocking keeps running through
    // REPORT so bytes stream back-to-back without gap cycles.
    always_ff @(posedge core_clk or posedge core_rstn) begin
        if (core_rstn) begin
            csN_q       <= 1'b1;
            spiClk_q    <= 1'b0;
            sdoEnb_q    <= 1'b1;
            divCnt_q    <= 8'd0;
            bitCnt_q    <= 5'd0;
            rxBits_q    <= 3'd0;
            rxSr_q      <= 8'd0;
            txSr_q      <= {RD_CMD, RD_ADDR};
            byteCnt_q   <= 4'd0;
            checkbits_q <= 16'h0000;
            spivalue_q  <= 8'h00;
            done_q      <= 1'b0;
        end else begin
            if (state_q == START) begin
                checkbits_q <= 16'hA040;
            end
            if (state_q == CMD && csN_q) begin
                csN_q     <= 1'b0;
                sdoEnb_q  <= 1'b0;
                divCnt_q  <= 8'd0;
                txSr_q    <= {RD_CMD, RD_ADDR};
                bitCnt_q  <= 5'd0;
                rxBits_q  <= 3'd0;
                byteCnt_q <= 4'd0;
            end
            if (inXfer) begin
                divCnt_q <= tick ? 8'd0 : divCnt_q + 8'd1;
            end
            if (riseEv) begin
                spiClk_q <= 1'b1;
                if (state_q inside {DATA, REPORT}) begin
                    rxSr_q   <= {rxSr_q[6:0], spi_miso};
                    rxBits_q <= rxBits_q + 3'd1;
                end
            end
            if (fallEv) begin
                spiClk_q <= 1'b0;
                if (state_q inside {CMD, ADDR}) begin
                    txSr_q   <= {txSr_q[30:0], 1'b0};
                    bitCnt_q <= bitCnt_q + 5'd1;
                    if (bitCnt_q == 5'd31) sdoEnb_q <= 1'b1;
                end
            end
            if (state_q == REPORT) begin
                spivalue_q  <= rxSr_q;
                checkbits_q <= 16'hA041 + {12'd0, byteCnt_q};
                byteCnt_q   <= byteCnt_q + 4'd1;
            end
            if (stopEnd) begin
                csN_q <= 1'b1;
            end
            if (state_q == DONE) begin
                checkbits_q <= 16'hA090;
                done_q      <= 1'b1;
            end
        end
    end

    // Output mapping; MOSI is forced low whenever the driver is disabled.
    always_comb begin
        la_output        = '0;
        la_output[31:16] = checkbits_q;
        la_output[15:8]  = spivalue_q;
        gpio_out_pad     = done_q;
        spi_clk          = spiClk_q;
        spi_cs_n         = csN_q;
        spi_sdoenb       = sdoEnb_q;
        spi_mosi         = !sdoEnb_q && txSr_q[31];
        flash_csb        = 1'b1;
        flash_clk        = 1'b0;
        flash_io0        = 1'b0;
    end

endmodule

// File: tb/tb_mgmt_core_wrapper.sv
// Bench for mgmt_core_wrapper: an SPI flash model feeds two instances
// (default parameters, and a one-byte CLK_DIV=1 variant); report events are
// checked against a queue of expected reports built from the flash contents.
module tb_mgmt_core_wrapper;

    localparam int NB_A = 11;
    localparam int DIV_A = 2;

    typedef struct packed {
        logic [15:0] cb;
        logic [7:0]  val;
        logic        gpio;
    } report_t;

    logic         clk;
    logic         rst;
    logic         flashIo1;
    logic [31:0]  mprjDat, hkDat;
    logic         mprjAck, hkAck;

    logic [127:0] laA, laB;
    logic         gpioA, gpioB;
    logic         sclkA, csA, mosiA, misoA, sdoA;
    logic         sclkB, csB, mosiB, misoB, sdoB;
    logic         fCsbA, fClkA, fIo0A, fCsbB, fClkB, fIo0B;

    logic [7:0]   mem [16];
    report_t      expQ [$];
    logic         mosiBits [$];
    logic         sdoBits [$];
    logic [23:0]  histB [$];

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int fallCntA = 0, fallCntB = 0;
    logic csPrevA = 1'b1, csPrevB = 1'b1;
    logic [127:0] prevLaA, prevLaB;
    logic prevGpioA, prevSclkA;
    int csLowA, csLowB, lastRiseA, minGapA, maxGapA;
    logic flashBad = 1'b0;

    mgmt_core_wrapper #(.CLK_DIV(DIV_A), .RD_CMD(8'h03), .RD_ADDR(24'h000000), .NBYTES(NB_A)) dutA (
        .core_clk(clk), .core_rstn(rst), .la_output(laA), .gpio_out_pad(gpioA),
        .spi_clk(sclkA), .spi_cs_n(csA), .spi_mosi(mosiA), .spi_miso(misoA), .spi_sdoenb(sdoA),
        .flash_csb(fCsbA), .flash_clk(fClkA), .flash_io0(fIo0A), .flash_io1(flashIo1),
        .mprj_dat_i(mprjDat), .hk_dat_i(hkDat), .mprj_ack_i(mprjAck), .hk_ack_i(hkAck));

    mgmt_core_wrapper #(.CLK_DIV(1), .RD_CMD(8'h03), .RD_ADDR(24'h000000), .NBYTES(1)) dutB (
        .core_clk(clk), .core_rstn(rst), .la_output(laB), .gpio_out_pad(gpioB),
        .spi_clk(sclkB), .spi_cs_n(csB), .spi_mosi(mosiB), .spi_miso(misoB), .spi_sdoenb(sdoB),
        .flash_csb(fCsbB), .flash_clk(fClkB), .flash_io0(fIo0B), .flash_io1(flashIo1),
        .mprj_dat_i(mprjDat), .hk_dat_i(hkDat), .mprj_ack_i(mprjAck), .hk_ack_i(hkAck));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Flash model: after 32 command/address bits, bit k of the read stream
    // is presented after the (32+k)th falling edge of spi_clk.
    function automatic logic slaveBit(input int fallCnt);
        int k;
        if (fallCnt < 32) return 1'b0;
        k = fallCnt - 32;
        return mem[(k / 8) % 16][7 - (k % 8)];
    endfunction

    always @(posedge csA or negedge csA or negedge sclkA) begin
        if (!csA) begin
            if (csPrevA) fallCntA = 0;
            else         fallCntA = fallCntA + 1;
        end
        csPrevA = csA;
    end

    always @(posedge csB or negedge csB or negedge sclkB) begin
        if (!csB) begin
            if (csPrevB) fallCntB = 0;
            else         fallCntB = fallCntB + 1;
        end
        csPrevB = csB;
    end

    always_comb misoA = slaveBit(fallCntA);
    always_comb misoB = slaveBit(fallCntB);

    // Inputs the design must ignore are scrambled every cycle.
    initial begin
        forever begin
            @(negedge clk);
            mprjDat  = $urandom;
            hkDat    = $urandom;
            mprjAck  = 1'($urandom);
            hkAck    = 1'($urandom);
            flashIo1 = 1'($urandom);
        end
    end

    task automatic checkOutput(input string name, input logic [131:0] actual, input logic [131:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: samples on the falling core edge, pops an expected report
    // whenever the analyser bus or done flag changes, and gathers SPI timing.
    always @(negedge clk) begin
        if (rst) begin
            prevLaA   = laA;
            prevGpioA = gpioA;
            prevSclkA = 1'b0;
            prevLaB   = laB;
            csLowA    = 0;
            csLowB    = 0;
            lastRiseA = 0;
            minGapA   = 1000000;
            maxGapA   = 0;
            mosiBits.delete();
            sdoBits.delete();
            histB.delete();
        end else begin
            report_t e;
            cyc++;
            if (!fCsbA || fClkA || fIo0A || !fCsbB || fClkB || fIo0B) flashBad = 1'b1;
            if (!csA) csLowA++;
            if (!csB) csLowB++;
            if (sclkA && !prevSclkA && !csA) begin
                mosiBits.push_back(mosiA);
                sdoBits.push_back(sdoA);
                if (mosiBits.size() > 1) begin
                    if (cyc - lastRiseA < minGapA) minGapA = cyc - lastRiseA;
                    if (cyc - lastRiseA > maxGapA) maxGapA = cyc - lastRiseA;
                end
                lastRiseA = cyc;
            end
            prevSclkA = sclkA;
            if (laA != prevLaA || gpioA != prevGpioA) begin
                if (expQ.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected report: got la %0h gpio %0b, expected none", laA[31:0], gpioA);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("report", {3'b0, gpioA, laA},
                                {3'b0, e.gpio, 96'b0, e.cb, e.val, 8'h00});
                end
            end
            prevLaA   = laA;
            prevGpioA = gpioA;
            if (laB != prevLaB) histB.push_back(laB[31:8]);
            prevLaB = laB;
        end
    end

    // Releases reset, pushes the full expected report sequence and checks
    // the opening handshake (progress code first, chip select one cycle later).
    task automatic applyStimulus();
        expQ.delete();
        expQ.push_back('{16'hA040, 8'h00, 1'b0});
        for (int i = 0; i < NB_A; i++) expQ.push_back('{16'(16'hA041 + i), mem[i], 1'b0});
        expQ.push_back('{16'hA090, mem[NB_A - 1], 1'b1});
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("start code", {116'b0, laA[31:16]}, {116'b0, 16'hA040});
        checkOutput("cs high in START", {131'b0, csA}, {131'b0, 1'b1});
        @(posedge clk); #1;
        checkOutput("cs low after START", {131'b0, csA}, {131'b0, 1'b0});
    endtask

    task automatic waitDoneAndCheck(input string tag);
        logic [31:0] cmdWord;
        int lowFirst, lowAfter, dataOnes;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (gpioA) break;
        end
        checkOutput({tag, " done in budget"}, {131'b0, gpioA}, {131'b0, 1'b1});
        repeat (3) @(negedge clk);
        checkOutput({tag, " queue drained"}, 132'(expQ.size()), 132'd0);
        checkOutput({tag, " rise count"}, 132'(mosiBits.size()), 132'(32 + 8 * NB_A));
        cmdWord = '0;
        lowFirst = 0; lowAfter = 0; dataOnes = 0;
        for (int i = 0; i < mosiBits.size(); i++) begin
            if (i < 32) begin
                cmdWord = {cmdWord[30:0], mosiBits[i]};
                if (sdoBits[i] == 1'b0) lowFirst++;
            end else begin
                if (sdoBits[i] == 1'b0) lowAfter++;
                if (mosiBits[i]) dataOnes++;
            end
        end
        checkOutput({tag, " mosi cmd+addr"}, {100'b0, cmdWord}, {100'b0, 32'h03000000});
        checkOutput({tag, " sdoenb low in cmd"}, 132'(lowFirst), 132'd32);
        checkOutput({tag, " sdoenb low in data"}, 132'(lowAfter), 132'd0);
        checkOutput({tag, " mosi idle in data"}, 132'(dataOnes), 132'd0);
        checkOutput({tag, " min spi period"}, 132'(minGapA), 132'(2 * DIV_A));
        checkOutput({tag, " max spi period"}, 132'(maxGapA), 132'(2 * DIV_A));
        checkOutput({tag, " cs low cycles"}, 132'(csLowA), 132'((32 + 8 * NB_A) * 2 * DIV_A + DIV_A));
        checkOutput({tag, " final la"}, {4'b0, laA}, {4'b0, 96'b0, 16'hA090, mem[NB_A - 1], 8'h00});
    endtask

    initial begin
        logic [7:0] initMem [16];
        int d;
        initMem = '{8'h93, 8'h01, 8'h00, 8'h13, 8'h02, 8'h63, 8'h57, 8'hb5,
                    8'h00, 8'h23, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        mem = initMem;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset cs", {131'b0, csA}, {131'b0, 1'b1});
        checkOutput("reset sclk/mosi/sdoenb", {129'b0, sclkA, mosiA, sdoA}, {129'b0, 3'b001});
        checkOutput("reset la/gpio", {3'b0, gpioA, laA}, 132'd0);

        $display("[TB] run 1: fixed flash contents");
        applyStimulus();
        waitDoneAndCheck("run1");
        repeat (20) @(posedge clk); #1;
        checkOutput("done holds", {3'b0, gpioA, laA}, {3'b0, 1'b1, 96'b0, 16'hA090, 8'h20, 8'h00});

        $display("[TB] run 2: reset during fifth data byte");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        applyStimulus();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (laA[31:16] == 16'hA044) break;
        end
        checkOutput("reached byte 5", {116'b0, laA[31:16]}, {116'b0, 16'hA044});
        d = $urandom_range(2, 24);
        repeat (d) @(posedge clk);
        #2;
        checkOutput("cs low before abort", {131'b0, csA}, {131'b0, 1'b0});
        rst = 1'b1;
        #1;
        checkOutput("abort cs", {131'b0, csA}, {131'b0, 1'b1});
        checkOutput("abort la", {4'b0, laA}, 132'd0);
        repeat (3) @(posedge clk);
        applyStimulus();
        waitDoneAndCheck("run2");

        $display("[TB] run 3: random flash contents");
        rst = 1'b1;
        foreach (mem[i]) mem[i] = 8'($urandom);
        repeat (2) @(posedge clk);
        applyStimulus();
        waitDoneAndCheck("run3");

        checkOutput("flash idle", {131'b0, flashBad}, 132'd0);
        checkOutput("B done", {131'b0, gpioB}, {131'b0, 1'b1});
        checkOutput("B cs low cycles", 132'(csLowB), 132'(81));
        checkOutput("B report count", 132'(histB.size()), 132'd3);
        if (histB.size() == 3) begin
            checkOutput("B start", {108'b0, histB[0]}, {108'b0, 16'hA040, 8'h00});
            checkOutput("B byte", {108'b0, histB[1]}, {108'b0, 16'hA041, mem[0]});
            checkOutput("B done code", {108'b0, histB[2]}, {108'b0, 16'hA090, mem[0]});
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
